instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the word address to the memory's 32-bit Address input.
- Takes the combinational 32-bit Instruction back and registers it, with PC+4 and a valid bit, into the IF/ID pipeline register consumed by decode.
- Handles stall, flush and branch/jump redirect from later stages, and keeps a fetch counter.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset; bits [1:0] are forced to 0.
- HALT_WORD, 32'hFFFF_FFFF: instruction encoding that halts fetch; used only with the optional feature.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-low reset.
- ImemAddress  output  32  byte address to instruction memory; always equals PC.
- ImemInstruction  input  32  instruction returned combinationally for ImemAddress.
- Stall  input  1  hazard unit request: hold PC and IF/ID.
- Flush  input  1  insert a bubble into IF/ID.
- Redirect  input  1  taken branch or jump.
- RedirectTarget  input  32  new PC when Redirect=1.
- IFID_Instruction  output  32  registered instruction.
- IFID_PCPlus4  output  32  registered PC+4 of that instruction.
- IFID_Valid  output  1  1 = IF/ID holds a real instruction.
- Misaligned  output  1  sticky: a redirect target had nonzero bits [1:0].
- FetchCount  output  32  number of instructions accepted into IF/ID.
- Halted  output  1  fetch stopped (optional feature only; otherwise tied 0).

Behaviour:
- Reset (Rst=0, asynchronous, effective immediately mid-operation):
  - PC=RESET_PC&~3.
  - IFID_Instruction=0, IFID_PCPlus4=0, IFID_Valid=0.
  - Misaligned=0, FetchCount=0, Halted=0.
  - State=RUN.
- ImemAddress=PC combinationally. The memory's response is sampled in the same cycle, so the fetch-to-IF/ID latency is 1 clock.
- PC update per rising edge, in priority order:
  1. Redirect=1: PC<=RedirectTarget&~3. If RedirectTarget[1:0]!=0, Misaligned<=1 (sticky until reset).
  2. Else Stall=1: PC holds.
  3. Else: PC<=PC+4, mod 2^32. PC 32'hFFFF_FFFC wraps to 0.
- IF/ID update per rising edge, in priority order:
  1. Redirect=1 or Flush=1: IFID_Valid<=0, IFID_Instruction<=0, IFID_PCPlus4 holds.
  2. Else Stall=1: all IF/ID fields hold.
  3. Else: IFID_Instruction<=ImemInstruction, IFID_PCPlus4<=PC+4, IFID_Valid<=1, FetchCount<=FetchCount+1 (wraps at 2^32).
- Simultaneous events:
  - Redirect wins over Stall for both PC and IF/ID.
  - Flush with Stall and no Redirect: PC holds, IF/ID is bubbled.
- States: RUN only, unless the optional feature adds HALT.
- A stall for N cycles leaves ImemAddress stable for N cycles and performs no counter increment.

Optional Feature:
- Macro: IFU_HALT_DETECT_EN.
- When defined:
  - In RUN, on an edge that would load IF/ID (case 3) with ImemInstruction==HALT_WORD, the word is loaded with IFID_Valid<=1 and FetchCount increments.
  - PC does not advance, and State<=HALT with Halted=1.
  - In HALT, PC holds. IF/ID receives a bubble each edge (Valid<=0) unless Stall=1.
  - In HALT, Redirect=1 still applies its PC update, returns State to RUN and clears Halted.
  - Only reset or Redirect leaves HALT.
- When undefined: HALT_WORD is fetched as an ordinary instruction and Halted is constant 0.

Test Plan:
- Reset release, no stalls, memory returning 0x20080001, 0x20090002, ... → ImemAddress steps 0, 4, 8; IFID_PCPlus4=4, 8, 12 one cycle behind; FetchCount=3 after 3 edges.
- Stall held 2 cycles at PC=8 → ImemAddress stays 8; IF/ID unchanged; FetchCount unchanged; sequence resumes with PC=12.
- Redirect with target 0x40 and Stall=1 on the same edge → PC=0x40, IFID_Valid=0; next edge IFID_PCPlus4=0x44.
- Redirect with target 0x42 → PC=0x40, Misaligned=1 and stays 1 until Rst pulses low.
- Rst asserted asynchronously between edges while PC=0x1C → PC, outputs and counter return to reset values before the next edge; PC steps from RESET_PC after release.
- With IFU_HALT_DETECT_EN defined, HALT_WORD at address 0x10 → Halted=1 and PC stuck at 0x10; bubbles follow; Redirect with target 0 resumes fetch from 0 and clears Halted.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction memory address and registers
// the returned word into IF/ID. Optional halt-word detection via IFU_HALT_DETECT_EN.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        Clk,
    input  logic        Rst,
    output logic [31:0] ImemAddress,
    input  logic [31:0] ImemInstruction,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid,
    output logic        Misaligned,
    output logic [31:0] FetchCount,
    output logic        Halted
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] PC_INIT    = RESET_PC & ALIGN_MASK;

`ifdef IFU_HALT_DETECT_EN
    typedef enum logic {ST_RUN, ST_HALT} state_t;
    state_t state_q, state_d;
    logic   halted_q, halted_d;
`endif

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pcp4_q, pcp4_d;
    logic            valid_q, valid_d;
    logic            mis_q, mis_d;
    logic [XLEN-1:0] count_q, count_d;
    logic [XLEN-1:0] pc_plus4_c;
    logic            advance_c, fetch_c, bubble_c;

    // Next-state: PC, IF/ID and bookkeeping from redirect/flush/stall priorities
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        pcp4_d     = pcp4_q;
        valid_d    = valid_q;
        mis_d      = mis_q;
        count_d    = count_q;
        pc_plus4_c = pc_q + XLEN'(4);
        advance_c  = !Redirect && !Stall;
        fetch_c    = !Redirect && !Flush && !Stall;
        bubble_c   = Redirect || Flush;
`ifdef IFU_HALT_DETECT_EN
        state_d    = state_q;
        if (state_q == ST_HALT) begin
            // Parked: PC frozen, IF/ID drains to bubbles unless stalled
            advance_c = 1'b0;
            fetch_c   = 1'b0;
            bubble_c  = Redirect || Flush || !Stall;
        end else if (fetch_c && (ImemInstruction == HALT_WORD)) begin
            advance_c = 1'b0;
            state_d   = ST_HALT;
        end
        if (Redirect) begin
            state_d = ST_RUN;
        end
        halted_d = (state_d == ST_HALT);
`endif

        if (Redirect) begin
            pc_d = RedirectTarget & ALIGN_MASK;
            if (RedirectTarget[1:0] != 2'b00) begin
                mis_d = 1'b1;
            end
        end else if (advance_c) begin
            pc_d = pc_plus4_c;
        end

        if (fetch_c) begin
            instr_d = ImemInstruction;
            pcp4_d  = pc_plus4_c;
            valid_d = 1'b1;
            count_d = count_q + XLEN'(1);
        end else if (bubble_c) begin
            instr_d = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pc_q     <= PC_INIT;
            instr_q  <= '0;
            pcp4_q   <= '0;
            valid_q  <= 1'b0;
            mis_q    <= 1'b0;
            count_q  <= '0;
`ifdef IFU_HALT_DETECT_EN
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
`endif
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pcp4_q   <= pcp4_d;
            valid_q  <= valid_d;
            mis_q    <= mis_d;
            count_q  <= count_d;
`ifdef IFU_HALT_DETECT_EN
            state_q  <= state_d;
            halted_q <= halted_d;
`endif
        end
    end

    assign ImemAddress      = pc_q;
    assign IFID_Instruction = instr_q;
    assign IFID_PCPlus4     = pcp4_q;
    assign IFID_Valid       = valid_q;
    assign Misaligned       = mis_q;
    assign FetchCount       = count_q;

`ifdef IFU_HALT_DETECT_EN
    assign Halted = halted_q;
`else
    // Halt word is an ordinary instruction in this build
    logic halt_word_unused;
    assign halt_word_unused = ^HALT_WORD;
    assign Halted           = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a rule-level model pushes the
// expected post-edge state; a monitor pops and compares after each edge/reset.
module tb_instruction_fetch_unit;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
`ifdef IFU_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic [31:0] ImemAddress;
    logic [31:0] ImemInstruction;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectTarget = 32'h0;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;
    logic        Misaligned;
    logic [31:0] FetchCount;
    logic        Halted;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcp4;
        logic [31:0] count;
        logic        valid;
        logic        mis;
        logic        halted;
    } exp_t;

    exp_t exp_q[$];
    exp_t m;

    instruction_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .HALT_WORD(HALT_WORD)
    ) dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .ImemAddress     (ImemAddress),
        .ImemInstruction (ImemInstruction),
        .Stall           (Stall),
        .Flush           (Flush),
        .Redirect        (Redirect),
        .RedirectTarget  (RedirectTarget),
        .IFID_Instruction(IFID_Instruction),
        .IFID_PCPlus4    (IFID_PCPlus4),
        .IFID_Valid      (IFID_Valid),
        .Misaligned      (Misaligned),
        .FetchCount      (FetchCount),
        .Halted          (Halted)
    );

    always #5 Clk = ~Clk;

    // Instruction memory: 0x20080001, 0x20090002, ... with the halt word at 0x10
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return HALT_WORD;
        return 32'h2008_0001 + 32'h0001_0001 * (a >> 2);
    endfunction

    assign ImemInstruction = mem_word(ImemAddress);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t reset_state();
        exp_t r;
        r.pc = 32'h0; r.instr = 32'h0; r.pcp4 = 32'h0; r.count = 32'h0;
        r.valid = 1'b0; r.mis = 1'b0; r.halted = 1'b0;
        return r;
    endfunction

    // One clock of stimulus; the model applies the fetch rules to predict the result
    task automatic step(input bit st, input bit fl, input bit rd, input logic [31:0] tg);
        exp_t nxt;
        logic [31:0] word;
        @(negedge Clk);
        Rst = 1'b1; Stall = st; Flush = fl; Redirect = rd; RedirectTarget = tg;
        word = mem_word(m.pc);
        nxt = m;
        if (rd) begin
            nxt.pc = {tg[31:2], 2'b00};
            if (tg[1:0] != 2'b00) nxt.mis = 1'b1;
            nxt.halted = 1'b0;
        end else if (!st && !m.halted) begin
            nxt.pc = m.pc + 32'd4;
        end
        if (rd || fl) begin
            nxt.valid = 1'b0;
            nxt.instr = 32'h0;
        end else if (!st) begin
            if (m.halted) begin
                nxt.valid = 1'b0;
                nxt.instr = 32'h0;
            end else begin
                nxt.instr = word;
                nxt.pcp4  = m.pc + 32'd4;
                nxt.valid = 1'b1;
                nxt.count = m.count + 32'd1;
                if (HALT_EN && word == HALT_WORD) begin
                    nxt.halted = 1'b1;
                    nxt.pc     = m.pc;
                end
            end
        end
        m = nxt;
        exp_q.push_back(m);
    endtask

    // Assert reset between edges, then hold it for extra edges
    task automatic async_reset(input int hold);
        @(negedge Clk);
        #2;
        m = reset_state();
        exp_q.push_back(m);
        Rst = 1'b0;
        exp_q.push_back(m);
        for (int k = 0; k < hold; k++) begin
            @(negedge Clk);
            exp_q.push_back(m);
        end
    endtask

    // Monitor: compare DUT state after each edge and on reset assertion
    initial begin
        exp_t e;
        #1;
        forever begin
            @(posedge Clk or negedge Rst);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ImemAddress", ImemAddress, e.pc);
                chk("IFID_Instruction", IFID_Instruction, e.instr);
                chk("IFID_PCPlus4", IFID_PCPlus4, e.pcp4);
                chk("IFID_Valid", 32'(IFID_Valid), 32'(e.valid));
                chk("Misaligned", 32'(Misaligned), 32'(e.mis));
                chk("FetchCount", FetchCount, e.count);
                chk("Halted", 32'(Halted), 32'(e.halted));
            end
        end
    end

    initial begin
        bit st, fl, rd;
        logic [31:0] tg;
        m = reset_state();
        exp_q.push_back(m);
        @(negedge Clk);
        exp_q.push_back(m);

        // Directed walk through the fetch scenarios
        step(0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        step(1, 0, 0, 32'h0);
        step(1, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        step(1, 0, 1, 32'h40);
        step(0, 0, 0, 32'h0);
        step(0, 0, 1, 32'h42);
        step(0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        step(1, 1, 0, 32'h0);
        step(0, 1, 0, 32'h0);
        step(0, 0, 1, 32'h10);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0);
        step(1, 0, 0, 32'h0);
        step(0, 0, 1, 32'h0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 32'h0);
        async_reset(1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0);
        step(0, 0, 1, 32'hFFFF_FFF8);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0);

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            rd = ($urandom_range(0, 99) < 8);
            st = ($urandom_range(0, 99) < 20);
            fl = ($urandom_range(0, 99) < 10);
            case ($urandom_range(0, 3))
                0:       tg = 32'($urandom_range(0, 255));
                1:       tg = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                2:       tg = $urandom();
                default: tg = 32'h10;
            endcase
            if ($urandom_range(0, 399) == 0) async_reset($urandom_range(0, 2));
            else step(st, fl, rd, tg);
        end

        repeat (2) @(negedge Clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
